// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the hazard/stall controller.
//   ST_RUN / ST_BUSY : controller state encodings (2-bit)
//   REG_X0           : architectural zero register, never a real hazard source
package hazard_stall_ctrl_pkg;
    localparam logic [1:0] ST_RUN  = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [4:0] REG_X0  = 5'd0;
endpackage

// File: rtl/hazard_stall_ctrl_muldiv_stall_counter.sv
// Mul/div remaining-stall counter.
//   clk, reset : clock, synchronous active-high reset (cnt -> 0)
//   load       : load load_val (takes precedence over dec)
//   load_val   : initial remaining-stall count
//   dec        : decrement by one
//   cnt        : current count; holds when neither load nor dec
//   zero       : cnt == 0
module hazard_stall_ctrl_muldiv_stall_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic [CW-1:0] cnt,
    output logic          zero
);
    always_ff @(posedge clk) begin
        if (reset)     cnt <= '0;
        else if (load) cnt <= load_val;
        else if (dec)  cnt <= cnt - CW'(1);
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard/stall controller for the 5-stage RV32 core.
//   clk, reset                  : clock, synchronous active-high reset
//   id_rs1/rs2, id_uses_rs1/rs2 : sources of the instruction in ID
//   ex_rd, ex_mem_read          : destination / load flag of the instruction in EX
//   ex_branch_taken             : EX redirects the PC
//   ex_muldiv_start             : EX holds a mul/div (level)
//   mem_wait                    : data memory not ready, freeze everything
//   hazDetect_PC                : PC load enable
//   ifid_*/idex_*/exmem_*       : pipeline register enables and NOP-inserts
//   muldiv_done                 : mul/div result valid in EX this cycle
//   stall_cycles                : count of cycles with hazDetect_PC==0 (wraps)
// Outputs are Mealy: decoded from current state and inputs in the same cycle.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             ex_muldiv_start,
    input  logic             mem_wait,
    output logic             hazDetect_PC,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic             exmem_bubble,
    output logic             muldiv_done,
    output logic [CNT_W-1:0] stall_cycles
);
    // Counter only needs to hold MULDIV_LAT-2 (the remaining stall count after
    // the first stall cycle).
    localparam int            CW       = (MULDIV_LAT > 2) ? $clog2(MULDIV_LAT - 1) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'((MULDIV_LAT >= 2) ? MULDIV_LAT - 2 : 0);

    logic [1:0]    state, state_nxt;
    logic          cnt_load, cnt_dec, cnt_zero;
    logic [CW-1:0] cnt;
    logic          load_use;

    hazard_stall_ctrl_muldiv_stall_counter #(.CW(CW)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (LOAD_VAL),
        .dec      (cnt_dec),
        .cnt      (cnt),
        .zero     (cnt_zero)
    );

    assign load_use = ex_mem_read && (ex_rd != REG_X0) &&
                      ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                       (id_uses_rs2 && (id_rs2 == ex_rd)));

    always_comb begin
        hazDetect_PC = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_write  = 1'b1;
        exmem_bubble = 1'b0;
        muldiv_done  = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
        state_nxt    = state;

        // Reset is decoded first so X on any other input cannot reach outputs.
        if (reset) begin
            ifid_flush   = 1'b1;
            idex_bubble  = 1'b1;
            exmem_bubble = 1'b1;
            state_nxt    = ST_RUN;
        end else if (mem_wait) begin
            hazDetect_PC = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
        end else if (state == ST_BUSY) begin
            if (!cnt_zero) begin
                hazDetect_PC = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_bubble = 1'b1;
                cnt_dec      = 1'b1;
            end else begin
                // ex_muldiv_start is still high here for the same instruction;
                // it must not retrigger.
                muldiv_done = 1'b1;
                state_nxt   = ST_RUN;
            end
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (ex_muldiv_start) begin
            if (MULDIV_LAT >= 2) begin
                hazDetect_PC = 1'b0;
                ifid_write   = 1'b0;
                idex_write   = 1'b0;
                exmem_bubble = 1'b1;
                cnt_load     = 1'b1;
                state_nxt    = ST_BUSY;
            end else begin
                muldiv_done = 1'b1;
            end
        end else if (load_use) begin
            // ID/EX stays enabled so it captures the bubble.
            hazDetect_PC = 1'b0;
            ifid_write   = 1'b0;
            idex_bubble  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_RUN;
            stall_cycles <= '0;
        end else begin
            state <= state_nxt;
            if (!hazDetect_PC) stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end
endmodule
